// File: rtl/mips_pkg.sv
// Shared MIPS32 core definitions: op encodings, op classes, mem/wb FSM states.
package mips_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  // Decode op encoding, shared with the decode stage.
  localparam logic [15:0] OP_ADD  = 16'h0001;
  localparam logic [15:0] OP_SUB  = 16'h0002;
  localparam logic [15:0] OP_AND  = 16'h0003;
  localparam logic [15:0] OP_OR   = 16'h0004;
  localparam logic [15:0] OP_XOR  = 16'h0005;
  localparam logic [15:0] OP_NOR  = 16'h0006;
  localparam logic [15:0] OP_SLT  = 16'h0007;
  localparam logic [15:0] OP_ADDI = 16'h0008;
  localparam logic [15:0] OP_ANDI = 16'h0009;
  localparam logic [15:0] OP_ORI  = 16'h000A;
  localparam logic [15:0] OP_LW   = 16'h000B;
  localparam logic [15:0] OP_SW   = 16'h000C;
  localparam logic [15:0] OP_SLL  = 16'h000D;
  localparam logic [15:0] OP_SRL  = 16'h000E;
  localparam logic [15:0] OP_LUI  = 16'h000F;
  localparam logic [15:0] OP_BEQ  = 16'h0010;
  localparam logic [15:0] OP_BNE  = 16'h0011;
  localparam logic [15:0] OP_J    = 16'h0012;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LW,
    CLS_SW,
    CLS_BR,
    CLS_J,
    CLS_ILL
  } op_cls_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM,
    ST_WAIT,
    ST_CAPT,
    ST_WB
  } state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bus between execute/memory/register file and the memory + write-back stage.
interface mem_wb_stage_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [15:0]       op;
  logic [31:0]       alu_result;
  logic [31:0]       store_data;
  logic [4:0]        dest_reg;
  logic              zero_flag;
  logic              busy;
  logic              done;
  logic              illegal;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_we;
  logic [31:0]       dmem_rdata;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;

  // Environment side: execute request plus the data-memory read return.
  modport master (
    output start, op, alu_result, store_data, dest_reg, zero_flag, dmem_rdata,
    input  busy, done, illegal, dmem_addr, dmem_wdata, dmem_we,
           rf_we, rf_waddr, rf_wdata, pc_load, pc_target
  );

  // Stage side.
  modport slave (
    input  start, op, alu_result, store_data, dest_reg, zero_flag, dmem_rdata,
    output busy, done, illegal, dmem_addr, dmem_wdata, dmem_we,
           rf_we, rf_waddr, rf_wdata, pc_load, pc_target
  );
endinterface

// File: rtl/mem_wb_stage_op_classifier.sv
// Combinational op -> op-class mapping; also usable by decode.
module op_classifier
  import mips_pkg::*;
(
  input  logic [15:0] op,
  output op_cls_e     cls
);

  // Map each known op to its class, everything else is illegal.
  always_comb begin
    cls = CLS_ILL;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLL, OP_SRL, OP_LUI: cls = CLS_ALU;
      OP_LW:                                            cls = CLS_LW;
      OP_SW:                                            cls = CLS_SW;
      OP_BEQ, OP_BNE:                                   cls = CLS_BR;
      OP_J:                                             cls = CLS_J;
      default:                                          cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage of the multicycle MIPS32 core.
// Every output is a flop; strobes are single-cycle and coincide with done
// except the lw address phase, which precedes it.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int MEM_RD_LATENCY = 1,
  parameter int ADDR_W         = 10
) (
  input logic           clk,
  input logic           rst,
  mem_wb_stage_if.slave bus
);

  // WAIT lasts MEM_RD_LATENCY-1 cycles; the counter runs down to zero.
  localparam logic [1:0] CNT_INIT = 2'((MEM_RD_LATENCY > 1) ? MEM_RD_LATENCY - 2 : 0);

  op_cls_e cls_in;

  state_e            state_q, state_d;
  op_cls_e           cls_q, cls_d;
  logic [4:0]        dest_q, dest_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]       dmem_wdata_q, dmem_wdata_d;
  logic              dmem_we_q, dmem_we_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [31:0]       rf_wdata_q, rf_wdata_d;
  logic              pc_load_q, pc_load_d;
  logic [ADDR_W-1:0] pc_target_q, pc_target_d;

  op_classifier u_cls (
    .op  (bus.op),
    .cls (cls_in)
  );

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    dest_d       = dest_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    dmem_we_d    = 1'b0;
    rf_we_d      = 1'b0;
    pc_load_d    = 1'b0;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    pc_target_d  = pc_target_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cls_d  = cls_in;
          dest_d = bus.dest_reg;
          case (cls_in)
            CLS_ALU: begin
              state_d = ST_WB;
              done_d  = 1'b1;
              // $zero is not writable: suppress the strobe, keep timing.
              if (bus.dest_reg != 5'd0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = bus.dest_reg;
                rf_wdata_d = bus.alu_result;
              end
            end
            CLS_SW: begin
              state_d      = ST_MEM;
              done_d       = 1'b1;
              dmem_we_d    = 1'b1;
              dmem_addr_d  = bus.alu_result[ADDR_W-1:0];
              dmem_wdata_d = bus.store_data;
            end
            CLS_LW: begin
              state_d     = ST_MEM;
              dmem_addr_d = bus.alu_result[ADDR_W-1:0];
            end
            CLS_BR: begin
              state_d     = ST_WB;
              done_d      = 1'b1;
              pc_load_d   = bus.zero_flag;
              pc_target_d = bus.alu_result[ADDR_W-1:0];
            end
            CLS_J: begin
              // Jump target arrives as a byte address; the PC is word-addressed.
              state_d     = ST_WB;
              done_d      = 1'b1;
              pc_load_d   = 1'b1;
              pc_target_d = bus.alu_result[ADDR_W+1:2];
            end
            default: begin
              state_d   = ST_WB;
              done_d    = 1'b1;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      ST_MEM: begin
        if (cls_q == CLS_LW) begin
          if (MEM_RD_LATENCY > 1) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_CAPT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) state_d = ST_CAPT;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_CAPT: begin
        // Read data is valid this cycle; the rf_wdata flop is the holding register.
        state_d = ST_WB;
        done_d  = 1'b1;
        if (dest_q != 5'd0) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = dest_q;
          rf_wdata_d = bus.dmem_rdata;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // busy covers everything after acceptance up to and including done.
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears everything, abandoning any lw.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cls_q        <= CLS_ALU;
      dest_q       <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_we_q    <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      pc_load_q    <= 1'b0;
      pc_target_q  <= '0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      dest_q       <= dest_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      pc_load_q    <= pc_load_d;
      pc_target_q  <= pc_target_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.illegal    = illegal_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.pc_load    = pc_load_q;
  assign bus.pc_target  = pc_target_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: one instance with 1-cycle read latency and
// one with 3-cycle latency (for the mid-lw reset case), each with a RAM model.
module tb_mem_wb_stage;

  typedef struct {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        dmem_we;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        pc_load;
    logic [9:0]  pc_target;
    logic        illegal;
    int          lat;
  } exp_t;

  logic clk;
  logic rst1, rst3;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  mem_wb_stage_if #(.ADDR_W(10)) if1 ();
  mem_wb_stage_if #(.ADDR_W(10)) if3 ();

  mem_wb_stage #(.MEM_RD_LATENCY(1), .ADDR_W(10)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1)
  );

  mem_wb_stage #(.MEM_RD_LATENCY(3), .ADDR_W(10)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (if3)
  );

  always #5 clk = ~clk;

  // Synchronous RAM models: 1-cycle and 3-cycle read latency.
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] rd1, rd3a, rd3b, rd3c;

  always @(posedge clk) begin
    if (if1.dmem_we) mem1[if1.dmem_addr] <= if1.dmem_wdata;
    rd1 <= mem1[if1.dmem_addr];
  end

  always @(posedge clk) begin
    if (if3.dmem_we) mem3[if3.dmem_addr] <= if3.dmem_wdata;
    rd3a <= mem3[if3.dmem_addr];
    rd3b <= rd3a;
    rd3c <= rd3b;
  end

  assign if1.dmem_rdata = rd1;
  assign if3.dmem_rdata = rd3c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic rf_we, input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic dm_we, input logic [9:0] daddr, input logic [31:0] dwdata,
                              input logic pcl, input logic [9:0] pct, input logic ill, input int lat);
    exp_t e;
    e.rf_we = rf_we;     e.rf_waddr = waddr;   e.rf_wdata = wdata;
    e.dmem_we = dm_we;   e.dmem_addr = daddr;  e.dmem_wdata = dwdata;
    e.pc_load = pcl;     e.pc_target = pct;    e.illegal = ill;
    e.lat = lat;
    return e;
  endfunction

  // Issue one op on the 1-cycle instance, then check the done cycle against
  // the scoreboard entry and confirm busy drops the cycle after.
  task automatic do_op(input string tag, input logic [15:0] op, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] dr, input logic zf, input exp_t e);
    int   n;
    bit   seen;
    exp_t x;
    sb.push_back(e);
    @(posedge clk); #1;
    if1.start = 1'b1; if1.op = op; if1.alu_result = alu;
    if1.store_data = sd; if1.dest_reg = dr; if1.zero_flag = zf;
    n = 0;
    seen = 0;
    while (!seen && n < 12) begin
      @(posedge clk); n++; #1;
      if1.start = 1'b0;
      if1.alu_result = 32'hA5A5_A5A5; if1.store_data = 32'h5A5A_5A5A;
      if1.dest_reg = 5'd31; if1.zero_flag = ~zf;
      @(negedge clk);
      if (if1.done) seen = 1;
    end
    x = sb.pop_front();
    check({tag, ".done"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, n, x.lat);
    check({tag, ".rf_we"}, 32'(if1.rf_we), 32'(x.rf_we));
    check({tag, ".dmem_we"}, 32'(if1.dmem_we), 32'(x.dmem_we));
    check({tag, ".pc_load"}, 32'(if1.pc_load), 32'(x.pc_load));
    check({tag, ".illegal"}, 32'(if1.illegal), 32'(x.illegal));
    if (x.rf_we) begin
      check({tag, ".rf_waddr"}, 32'(if1.rf_waddr), 32'(x.rf_waddr));
      check({tag, ".rf_wdata"}, if1.rf_wdata, x.rf_wdata);
    end
    if (x.dmem_we) begin
      check({tag, ".dmem_addr"}, 32'(if1.dmem_addr), 32'(x.dmem_addr));
      check({tag, ".dmem_wdata"}, if1.dmem_wdata, x.dmem_wdata);
    end
    if (x.pc_load || op == 16'h0010)
      check({tag, ".pc_target"}, 32'(if1.pc_target), 32'(x.pc_target));
    @(negedge clk);
    check({tag, ".busy_after"}, 32'(if1.busy), 32'd0);
    check({tag, ".done_after"}, 32'(if1.done), 32'd0);
  endtask

  initial begin
    int          dn, wn;
    logic [4:0]  last_waddr;
    logic [31:0] last_wdata;
    exp_t        x;

    clk = 1'b0;
    rst1 = 1'b1; rst3 = 1'b1;
    if1.start = 1'b0; if1.op = '0; if1.alu_result = '0; if1.store_data = '0;
    if1.dest_reg = '0; if1.zero_flag = 1'b0;
    if3.start = 1'b0; if3.op = '0; if3.alu_result = '0; if3.store_data = '0;
    if3.dest_reg = '0; if3.zero_flag = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.busy", 32'(if1.busy), 0);
    check("reset.done", 32'(if1.done), 0);
    check("reset.strobes", {28'd0, if1.rf_we, if1.dmem_we, if1.pc_load, if1.illegal}, 0);
    check("reset.addrs", {12'd0, if1.dmem_addr, if1.pc_target}, 0);
    check("reset.rf_wdata", if1.rf_wdata, 0);
    #1; rst1 = 1'b0; rst3 = 1'b0;

    do_op("add", 16'h0001, 32'h0000_0007, 32'h0, 5'd3, 1'b0,
          mk(1, 5'd3, 32'd7, 0, 10'd0, 32'd0, 0, 10'd0, 0, 1));
    do_op("sw", 16'h000C, 32'h0000_0024, 32'hDEAD_BEEF, 5'd0, 1'b0,
          mk(0, 5'd0, 32'd0, 1, 10'h024, 32'hDEAD_BEEF, 0, 10'd0, 0, 1));
    do_op("lw", 16'h000B, 32'h0000_0024, 32'h0, 5'd8, 1'b0,
          mk(1, 5'd8, 32'hDEAD_BEEF, 0, 10'd0, 32'd0, 0, 10'd0, 0, 3));
    do_op("beq_taken", 16'h0010, 32'h0000_0015, 32'h0, 5'd0, 1'b1,
          mk(0, 5'd0, 32'd0, 0, 10'd0, 32'd0, 1, 10'h015, 0, 1));
    do_op("beq_not_taken", 16'h0010, 32'h0000_0015, 32'h0, 5'd0, 1'b0,
          mk(0, 5'd0, 32'd0, 0, 10'd0, 32'd0, 0, 10'h015, 0, 1));
    do_op("j", 16'h0012, 32'h0000_0040, 32'h0, 5'd0, 1'b0,
          mk(0, 5'd0, 32'd0, 0, 10'd0, 32'd0, 1, 10'h010, 0, 1));
    do_op("add_r0", 16'h0001, 32'h0000_0099, 32'h0, 5'd0, 1'b0,
          mk(0, 5'd0, 32'd0, 0, 10'd0, 32'd0, 0, 10'd0, 0, 1));
    do_op("illegal", 16'h0013, 32'h0000_0024, 32'h1111_1111, 5'd4, 1'b1,
          mk(0, 5'd0, 32'd0, 0, 10'd0, 32'd0, 0, 10'd0, 1, 1));
    // Upper address bits are dropped: 0xFFFFF424 lands on word 0x024.
    do_op("sw_wrap", 16'h000C, 32'hFFFF_F424, 32'h1234_5678, 5'd0, 1'b0,
          mk(0, 5'd0, 32'd0, 1, 10'h024, 32'h1234_5678, 0, 10'd0, 0, 1));

    // lw with start held high through its done cycle: only one completion.
    @(posedge clk); #1;
    if1.start = 1'b1; if1.op = 16'h000B; if1.alu_result = 32'h0000_0024; if1.dest_reg = 5'd8;
    dn = 0; wn = 0; last_waddr = '0; last_wdata = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (i >= 4) if1.start = 1'b0;
      else begin
        if1.op = 16'h0001; if1.alu_result = 32'h0000_0055; if1.dest_reg = 5'd9;
      end
      @(negedge clk);
      if (if1.done) dn++;
      if (if1.rf_we) begin
        wn++; last_waddr = if1.rf_waddr; last_wdata = if1.rf_wdata;
      end
    end
    check("busy_start.done_count", dn, 1);
    check("busy_start.rf_we_count", wn, 1);
    check("busy_start.rf_waddr", 32'(last_waddr), 32'd8);
    check("busy_start.rf_wdata", last_wdata, 32'h1234_5678);

    // Reset in the middle of a 3-cycle-latency lw.
    @(posedge clk); #1;
    if3.start = 1'b1; if3.op = 16'h000B; if3.alu_result = 32'h0000_0030; if3.dest_reg = 5'd5;
    @(posedge clk); #1;
    if3.start = 1'b0;
    @(negedge clk);
    check("rst_lw.addr_before", 32'(if3.dmem_addr), 32'h030);
    @(posedge clk); #1;
    rst3 = 1'b1;
    #1;
    check("rst_lw.busy", 32'(if3.busy), 0);
    check("rst_lw.dmem_addr", 32'(if3.dmem_addr), 0);
    check("rst_lw.strobes", {27'd0, if3.done, if3.rf_we, if3.dmem_we, if3.pc_load, if3.illegal}, 0);
    @(posedge clk); #1;
    rst3 = 1'b0;
    wn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if3.rf_we || if3.done || if3.pc_load) wn++;
    end
    check("rst_lw.no_late_strobe", wn, 0);

    // Fresh op after reset must work normally.
    sb.push_back(mk(1, 5'd6, 32'hCAFE_0001, 0, 10'd0, 32'd0, 0, 10'd0, 0, 1));
    @(posedge clk); #1;
    if3.start = 1'b1; if3.op = 16'h0002; if3.alu_result = 32'hCAFE_0001; if3.dest_reg = 5'd6;
    @(posedge clk); #1;
    if3.start = 1'b0;
    @(negedge clk);
    x = sb.pop_front();
    check("rst_lw.after.done", 32'(if3.done), 32'd1);
    check("rst_lw.after.rf_we", 32'(if3.rf_we), 32'(x.rf_we));
    check("rst_lw.after.rf_waddr", 32'(if3.rf_waddr), 32'(x.rf_waddr));
    check("rst_lw.after.rf_wdata", if3.rf_wdata, x.rf_wdata);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and write-back stage of the multicycle MIPS32 core.
- Sits downstream of the execute stage and consumes its ALU result, opcode class, store operand, destination index and branch flag.
- Performs data-memory reads and writes, register-file write-back, and PC redirect for branches and jumps.
- Pulses done back to the control FSM so it can return to fetch.

Parameters:
- MEM_RD_LATENCY, 1, cycles from dmem_addr valid to dmem_rdata valid (synchronous RAM); legal range 1..4.
- ADDR_W, 10, word-address width for data memory and PC (matches the 10-bit pc).

Ports:
- clk  in  1  core clock (derived clock, not CLOCK_50).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request from execute; inputs below are valid in the same cycle.
- op  in  16  operation code from decode (FSM2 encoding: 0x0001..0x0012).
- alu_result  in  32  execute-stage ALU output.
- store_data  in  32  rt register value, used by sw.
- dest_reg  in  5  write-back register index (already rd or rt, selected upstream).
- zero_flag  in  1  branch condition from execute (1 = take).
- busy  out  1  high from the cycle after an accepted start through the done cycle, inclusive.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse, coincident with done, for an unknown op.
- dmem_addr  out  ADDR_W  data-memory word address.
- dmem_wdata  out  32  data-memory write data.
- dmem_we  out  1  data-memory write strobe (one cycle).
- dmem_rdata  in  32  data-memory read data.
- rf_we  out  1  register-file write strobe (one cycle).
- rf_waddr  out  5  register-file write index.
- rf_wdata  out  32  register-file write data.
- pc_load  out  1  one-cycle PC redirect strobe.
- pc_target  out  ADDR_W  new PC word address.

Behaviour:
- All outputs are registered. Reset drives every output to 0 and the FSM to IDLE.
- Reset is asynchronous and takes effect mid-operation: a pending lw is abandoned and no rf_we or pc_load is issued afterwards.
- start is accepted only in IDLE (busy=0). Any start with busy=1, including in the done cycle, is ignored.
- On acceptance, op, alu_result, store_data, dest_reg and zero_flag are latched. Later changes on these inputs have no effect.
- Op classes:
  - ALU: 0x01-0x0A, 0x0D-0x0F.
  - LW: 0x0B.
  - SW: 0x0C.
  - BR: 0x10, 0x11.
  - J: 0x12.
  - Any other value is illegal.
- FSM states: IDLE, MEM, WAIT, CAPT, WB.
- ALU class: IDLE->WB. At cycle T+1 (start at T): rf_we=1, rf_waddr=dest_reg, rf_wdata=alu_result, done=1. Then IDLE.
- SW class: IDLE->MEM. At T+1: dmem_we=1, dmem_addr=alu_result[ADDR_W-1:0], dmem_wdata=store_data, done=1. Then IDLE.
- LW class, step 1: IDLE->MEM. At T+1: dmem_addr driven, dmem_we=0.
- LW class, step 2: WAIT for MEM_RD_LATENCY-1 cycles, then CAPT, which samples dmem_rdata into a holding register at T+1+MEM_RD_LATENCY.
- LW class, step 3: WB at T+2+MEM_RD_LATENCY: rf_we=1, rf_wdata=held data, done=1.
- LW total latency is MEM_RD_LATENCY+2 cycles. dmem_addr holds its value from MEM through CAPT.
- BR class: IDLE->WB. At T+1: pc_load=zero_flag, pc_target=alu_result[ADDR_W-1:0], done=1. No rf write.
- J class: IDLE->WB. At T+1: pc_load=1, pc_target=alu_result[ADDR_W+1:2] (alu_result is a byte address), done=1.
- Illegal op: at T+1, done=1 and illegal=1. No memory, register or PC side effect.
- dest_reg=0 for an ALU or LW op: rf_we stays 0 ($zero is not writable), done still pulses, timing is unchanged.
- Addresses wrap: only the low ADDR_W bits are used. Upper alu_result bits are ignored without error.
- Between operations, dmem_addr, rf_waddr, rf_wdata and pc_target hold their last values. All strobes are 0 except in the cycles defined above.

Decomposition:
- Shared package mips_pkg holds:
  - the OP_* localparams (0x0001 add ... 0x0012 j, same encoding as decode);
  - the op-class enum (CLS_ALU, CLS_LW, CLS_SW, CLS_BR, CLS_J, CLS_ILL);
  - the FSM state encoding;
  - ADDR_W and DATA_W=32.
- One sub-module is natural: op_classifier, a purely combinational mapping from the 16-bit op to the op class, reusable by decode.

Test Plan:
- add: op=0x0001, alu_result=0x0000_0007, dest_reg=3, start at T -> at T+1: rf_we=1, rf_waddr=3, rf_wdata=7, done=1. busy=0 at T+2.
- sw then lw, MEM_RD_LATENCY=1:
  - sw: op=0x000C, alu_result=0x24, store_data=0xDEADBEEF -> at T+1: dmem_we=1, dmem_addr=0x24.
  - lw: op=0x000B, alu_result=0x24, dest_reg=8, with the memory model returning the written data -> rf_we=1 with rf_wdata=0xDEADBEEF exactly 3 cycles after start.
- Branch:
  - beq, op=0x0010, zero_flag=1, alu_result=0x15 -> pc_load=1, pc_target=0x15.
  - Same op with zero_flag=0 -> pc_load=0, done=1.
- Jump: j, op=0x0012, alu_result=0x0000_0040 -> pc_load=1, pc_target=0x010.
- Edge cases:
  - op=0x0001 with dest_reg=0 -> rf_we=0, done=1.
  - op=0x0013 -> illegal=1, done=1, no strobes.
  - A second start asserted while busy=1 is ignored, so only one done is produced.
- Reset mid-lw: MEM_RD_LATENCY=3, assert rst at T+2 -> all outputs 0 immediately, no rf_we ever, and a new start after rst is released is processed normally.
